// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with a small word FIFO; configurable data width, parity, stop bits, bit period.
// First start bit one cycle after acceptance into an idle block; o_ready drops while the FIFO is full.
module uart_tx_fifo_param #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [AW:0]   LP_DEPTH     = FIFO_DEPTH[AW:0];
  localparam logic [BW-1:0] LP_BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LP_STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LP_DBIT_LAST = IW'(DATA_BITS - 1);
  localparam logic          LP_ODD       = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_count;
  logic [2:0]           r_state;
  logic [BW-1:0]        r_baud;
  logic [IW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic [DATA_BITS-1:0] w_head;

  assign o_ready      = (r_count < LP_DEPTH);
  assign o_fifo_count = r_count;
  assign o_tx         = r_tx;
  assign o_busy       = (r_state != S_IDLE);

  assign w_nonempty = (r_count != '0);
  assign w_bit_end  = (r_baud == LP_BIT_LAST);
  assign w_stop_end = (r_baud == LP_STOP_LAST);
  assign w_head     = r_mem[r_rptr];
  assign w_push     = i_valid && o_ready;
  // A frame is fetched either from idle or on the very last stop cycle, giving zero inter-frame gap.
  assign w_pop      = w_nonempty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= w_head;
      r_par   <= (^w_head) ^ LP_ODD;
      r_tx    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == LP_DBIT_LAST) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_baud  <= '0;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_stop_end) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: four configurations (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit,
// each compared every cycle against a queue-and-frame-timeline model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_param;

  localparam int C  = 4;
  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] vld;
  logic [NI-1:0] rdy;
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;
  logic [7:0]    dat [NI];
  logic [2:0]    cnt [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Model: FIFO contents plus position (in cycles) inside the frame on the line, -1 when idle.
  int          mq    [NI][16];
  int          mhead [NI];
  int          msize [NI];
  int          mpos  [NI];
  logic [15:0] mfr   [NI];

  always #5 clk = ~clk;

  uart_tx_fifo_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .i_rst_n(rst_n), .i_data(dat[0]), .i_valid(vld[0]), .o_ready(rdy[0]),
    .o_tx(tx[0]), .o_busy(busy[0]), .o_fifo_count(cnt[0]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .i_rst_n(rst_n), .i_data(dat[1]), .i_valid(vld[1]), .o_ready(rdy[1]),
    .o_tx(tx[1]), .o_busy(busy[1]), .o_fifo_count(cnt[1]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .i_rst_n(rst_n), .i_data(dat[2]), .i_valid(vld[2]), .o_ready(rdy[2]),
    .o_tx(tx[2]), .o_busy(busy[2]), .o_fifo_count(cnt[2]));
  uart_tx_fifo_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .i_rst_n(rst_n), .i_data(dat[3][6:0]), .i_valid(vld[3]), .o_ready(rdy[3]),
    .o_tx(tx[3]), .o_busy(busy[3]), .o_fifo_count(cnt[3]));

  function automatic int db(int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int par(int k);
    if (k == 1) return 2;
    if (k == 2) return 1;
    return 0;
  endfunction

  function automatic int sb(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int flen(int k);
    return (1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k)) * C;
  endfunction

  // Line level per bit slot: slot 0 start, then data LSB first, optional parity, then stop (all ones above).
  function automatic logic [15:0] frame(int k, logic [7:0] w);
    logic [15:0] f;
    logic        p;
    f = '1;
    p = 1'b0;
    f[0] = 1'b0;
    for (int i = 0; i < db(k); i++) begin
      f[1+i] = w[i];
      p      = p ^ w[i];
    end
    if (par(k) == 2) f[1+db(k)] = p;
    if (par(k) == 1) f[1+db(k)] = ~p;
    return f;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit acc;
    if (!rst_n) begin
      msize[k] = 0;
      mhead[k] = 0;
      mpos[k]  = -1;
      return;
    end
    acc = vld[k] && (msize[k] < 4);
    if (mpos[k] < 0 || mpos[k] == flen(k) - 1) begin
      if (msize[k] > 0) begin
        mfr[k]   = frame(k, 8'(mq[k][mhead[k]]));
        mhead[k] = (mhead[k] + 1) % 16;
        msize[k] = msize[k] - 1;
        mpos[k]  = 0;
      end else begin
        mpos[k] = -1;
      end
    end else begin
      mpos[k] = mpos[k] + 1;
    end
    if (acc) begin
      mq[k][(mhead[k] + msize[k]) % 16] = int'(dat[k]);
      msize[k] = msize[k] + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) model_step(k);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("tx",    k, tx[k],   (mpos[k] < 0) ? 1 : mfr[k][mpos[k] / C]);
      chk("busy",  k, busy[k], (mpos[k] >= 0) ? 1 : 0);
      chk("count", k, cnt[k],  msize[k]);
      chk("ready", k, rdy[k],  (msize[k] < 4) ? 1 : 0);
    end
  end

  initial begin
    int  bc [NI];
    int  w;
    int  guard;
    int  full_at;
    int  idle_bad;
    bit  s;
    logic [7:0] ab [3];

    rst_n = 1'b0;
    vld   = '0;
    for (int k = 0; k < NI; k++) dat[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_tx",    k, tx[k],   1);
      chk("rst_busy",  k, busy[k], 0);
      chk("rst_count", k, cnt[k],  0);
      chk("rst_ready", k, rdy[k],  1);
    end
    #2 rst_n = 1'b1;

    chk("frame_8n1_55", 0, frame(0, 8'h55), 16'hFEAA);
    chk("frame_8e1_07", 1, frame(1, 8'h07), 16'hFE0E);
    chk("frame_8o1_07", 2, frame(2, 8'h07), 16'hFC0E);
    chk("frame_7n2_7f", 3, frame(3, 8'h7F), 16'hFFFE);
    chk("flen_8n1", 0, flen(0), 40);
    chk("flen_8e1", 1, flen(1), 44);
    chk("flen_7n2", 3, flen(3), 40);

    // Single word into each configuration, accepted on the same edge.
    @(posedge clk); #2;
    vld = '1; dat[0] = 8'h55; dat[1] = 8'h07; dat[2] = 8'h07; dat[3] = 8'h7F;
    @(posedge clk); #2;
    vld = '0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk("start_low", k, tx[k], 0);
      bc[k] = 0;
    end
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < NI; k++) bc[k] += int'(busy[k]);
      @(posedge clk); #1;
    end
    for (int k = 0; k < NI; k++) chk("busy_len", k, bc[k], (k == 1 || k == 2) ? 44 : 40);

    // Hold i_valid with 1..6; source keeps each word until accepted.
    w = 1; guard = 0; full_at = -1;
    vld[0] = 1'b1; dat[0] = 8'(w);
    while (w <= 6 && guard < 400) begin
      @(negedge clk);
      s = rdy[0];
      if (!s && full_at < 0) full_at = w - 1;
      @(posedge clk); #2;
      if (s) begin
        w++;
        dat[0] = 8'(w);
      end
      guard++;
    end
    vld[0] = 1'b0;
    chk("burst_done", 0, w, 7);
    chk("ready_fall_after", 0, full_at, 5);
    repeat (300) @(posedge clk);

    // Push arriving on the same edge as the pop with two words queued.
    ab[0] = 8'hA1; ab[1] = 8'hB2; ab[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      vld[0] = 1'b1; dat[0] = ab[i];
    end
    @(posedge clk); #2;
    vld[0] = 1'b0;
    guard = 0;
    while (mpos[0] != 39 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_frame_end", 0, mpos[0], 39);
    chk("pre_simul_count", 0, cnt[0], 2);
    vld[0] = 1'b1; dat[0] = 8'hD4;
    @(posedge clk); #1;
    chk("simul_count", 0, cnt[0], 2);
    #1 vld[0] = 1'b0;
    repeat (200) @(posedge clk);

    // Asynchronous reset during data bit 3 with two words queued.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      vld[0] = 1'b1; dat[0] = 8'h30 + 8'(i);
    end
    @(posedge clk); #2;
    vld[0] = 1'b0;
    guard = 0;
    while (mpos[0] != 17 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_data_bit3", 0, mpos[0], 17);
    chk("queued_before_rst", 0, cnt[0], 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx",    0, tx[0],   1);
    chk("arst_busy",  0, busy[0], 0);
    chk("arst_count", 0, cnt[0],  0);
    chk("arst_ready", 0, rdy[0],  1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle_bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) idle_bad++;
    end
    chk("idle_after_rst", 0, idle_bad, 0);

    // Random traffic: light load, then heavy load that keeps the FIFOs full.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      for (int k = 0; k < NI; k++) begin
        vld[k] = ($urandom_range(0, 99) < ((c < 1500) ? 30 : 85));
        dat[k] = 8'($urandom);
      end
    end
    @(posedge clk); #2;
    vld = '0;
    repeat (300) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
